fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data/address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries and in-flight request limit (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 mem_req_valid  output  1  fetch request present.
REQ-007 mem_req_ready  input  1  memory accepts request.
REQ-008 mem_req_addr  output  WIDTH  word-aligned fetch address.
REQ-009 mem_rsp_valid  input  1  in-order response present (no backpressure).
REQ-010 mem_rsp_data  input  WIDTH  fetched instruction word.
REQ-011 inst_valid  output  1  buffer head holds an instruction for the datapath IR.
REQ-012 inst_ready  input  1  datapath consumes the head.
REQ-013 inst_data  output  WIDTH  head instruction word.
REQ-014 inst_pc  output  WIDTH  address of the head instruction.
REQ-015 redirect_valid  input  1  branch/jump redirect this cycle.
REQ-016 redirect_pc  input  WIDTH  new fetch address.

Function
REQ-017 Request handshake SHALL occur when mem_req_valid and mem_req_ready are both high; response capture when mem_rsp_valid is high; pop when inst_valid and inst_ready are both high.
REQ-018 mem_req_valid SHALL equal (buf_count + live_inflight + drop_count < DEPTH) and not redirect_valid, with no dependence on mem_req_ready.
REQ-019 mem_req_addr SHALL equal fetch_pc; fetch_pc SHALL advance by 4 (modulo 2^WIDTH, wrap from all-ones-minus-3 to 0) on each request handshake.
REQ-020 Each accepted request address SHALL be pushed into a DEPTH-entry in-flight PC queue; each live response SHALL pop it and write {data, pc} into the instruction buffer tail.
REQ-021 inst_valid SHALL be high exactly when buf_count > 0; inst_data/inst_pc SHALL reflect the head entry, registered (response to inst_valid latency one cycle).
REQ-022 Simultaneous response write and pop SHALL leave buf_count unchanged and preserve order; simultaneous request and response SHALL leave in-flight count unchanged.
REQ-023 Buffer overflow SHALL be impossible by REQ-018; a response arriving with no outstanding request is a protocol error and SHALL be ignored.
REQ-024 On redirect_valid: fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00}; buffer and in-flight PC queue SHALL flush; drop_count <= drop_count + live_inflight.
REQ-025 While drop_count > 0, each response SHALL be discarded and decrement drop_count; responses arriving in the redirect cycle itself SHALL be discarded.
REQ-026 A pop coinciding with redirect SHALL complete for the datapath; inst_valid SHALL be low the following cycle.
REQ-027 Consecutive redirects SHALL each apply; the last one sets fetch_pc.
REQ-028 First request SHALL be presented in the first cycle after rst deasserts.

Reset
REQ-029 While rst is low: fetch_pc=RESET_PC, buf_count=0, live_inflight=0, drop_count=0, mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-030 Reset asserted mid-operation SHALL abandon all outstanding requests without drop tracking; the memory model is reset in the same cycle.

Verification
REQ-031 Reset release, mem_req_ready=1, 1-cycle response memory, inst_ready=1 -> addresses 0x0,0x4,0x8... issued; inst_pc sequence 0x0,0x4,0x8 with matching data; first inst_valid 2 cycles after first request.
REQ-032 inst_ready=0 held -> exactly DEPTH (4) requests issued, buffer fills, mem_req_valid low until first pop.
REQ-033 Two requests in flight (0x10,0x14), redirect to 0x103 -> next request address 0x100, both stale responses discarded, first inst_pc 0x100.
REQ-034 Redirect coincident with response and pop -> popped instruction delivered, response dropped, inst_valid low next cycle.
REQ-035 RESET_PC=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-036 Random mem_req_ready/mem_rsp delay/inst_ready with random redirects -> delivered {pc,data} stream matches golden in-order model, no loss or duplication.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// Issues word-aligned fetch requests to an in-order memory, tags each request
// with its PC in an in-flight queue, and stages returned words in a small
// instruction buffer that feeds the datapath IR. A redirect flushes both
// queues and counts still-outstanding requests so that their stale responses
// can be discarded when they eventually return.
//
// Ports:
//   clk             sole clock, rising edge
//   rst             synchronous, active-low reset
//   mem_req_valid   fetch request present
//   mem_req_ready   memory accepts the request
//   mem_req_addr    word-aligned fetch address
//   mem_rsp_valid   in-order response present (no backpressure)
//   mem_rsp_data    fetched instruction word
//   inst_valid      buffer head holds an instruction
//   inst_ready      datapath consumes the head
//   inst_data       head instruction word
//   inst_pc         address of the head instruction
//   redirect_valid  branch/jump redirect this cycle
//   redirect_pc     new fetch address (low two bits ignored)
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst_data,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 2;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [OW-1:0] occ_t;

  // Control state
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  ptr_t             ifq_rd_q, ifq_rd_d, ifq_wr_q, ifq_wr_d;
  cnt_t             live_q, live_d;
  cnt_t             drop_q, drop_d;
  ptr_t             buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  cnt_t             buf_cnt_q, buf_cnt_d;

  // Storage (no reset; validity is carried by the counters)
  logic [WIDTH-1:0] ifq_pc_q   [DEPTH];
  logic [WIDTH-1:0] buf_data_q [DEPTH];
  logic [WIDTH-1:0] buf_pc_q   [DEPTH];

  logic req_fire, rsp_drop, rsp_live, rsp_write, pop;
  cnt_t live_after, drop_after;
  occ_t occ;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Every entry already buffered, in flight, or awaiting discard reserves a
  // buffer slot, so the buffer can never overflow.
  assign occ           = occ_t'(buf_cnt_q) + occ_t'(live_q) + occ_t'(drop_q);
  assign mem_req_valid = rst && !redirect_valid && (occ < occ_t'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;

  assign inst_valid = rst && (buf_cnt_q != '0);
  assign inst_data  = inst_valid ? buf_data_q[buf_rd_q] : '0;
  assign inst_pc    = inst_valid ? buf_pc_q[buf_rd_q]   : '0;

  assign req_fire  = mem_req_valid && mem_req_ready;
  // Stale responses are consumed first; a response with nothing outstanding
  // matches neither term and is ignored.
  assign rsp_drop  = mem_rsp_valid && (drop_q != '0);
  assign rsp_live  = mem_rsp_valid && (drop_q == '0) && (live_q != '0);
  assign rsp_write = rsp_live && !redirect_valid;
  assign pop       = inst_valid && inst_ready;

  always_comb begin
    live_after = live_q + cnt_t'(req_fire) - cnt_t'(rsp_live);
    drop_after = drop_q - cnt_t'(rsp_drop);

    fetch_pc_d = fetch_pc_q;
    ifq_rd_d   = ifq_rd_q + ptr_t'(rsp_live);
    ifq_wr_d   = ifq_wr_q + ptr_t'(req_fire);
    live_d     = live_after;
    drop_d     = drop_after;
    buf_rd_d   = buf_rd_q + ptr_t'(pop);
    buf_wr_d   = buf_wr_q + ptr_t'(rsp_write);
    buf_cnt_d  = buf_cnt_q + cnt_t'(rsp_write) - cnt_t'(pop);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + WIDTH'(4);
    end

    if (redirect_valid) begin
      // Whatever is still live at the end of this cycle becomes stale.
      fetch_pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
      ifq_rd_d   = '0;
      ifq_wr_d   = '0;
      live_d     = '0;
      drop_d     = drop_after + live_after;
      buf_rd_d   = '0;
      buf_wr_d   = '0;
      buf_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      ifq_rd_q   <= '0;
      ifq_wr_q   <= '0;
      live_q     <= '0;
      drop_q     <= '0;
      buf_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_cnt_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ifq_rd_q   <= ifq_rd_d;
      ifq_wr_q   <= ifq_wr_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      buf_rd_q   <= buf_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      ifq_pc_q[ifq_wr_q] <= fetch_pc_q;
    end
    if (rsp_write) begin
      buf_data_q[buf_wr_q] <= mem_rsp_data;
      buf_pc_q[buf_wr_q]   <= ifq_pc_q[ifq_rd_q];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, hand sequences for
// fill/wrap corners, and a long randomized run against a stream-level model.
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RESET0 = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        mem_req_valid, inst_valid;
  logic [31:0] mem_req_addr, inst_data, inst_pc;
  logic        d2_rv, d2_iv;
  logic [31:0] d2_addr, d2_data, d2_pc;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET0)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst),
    .mem_req_valid(d2_rv), .mem_req_ready(mem_req_ready), .mem_req_addr(d2_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(d2_iv), .inst_ready(inst_ready), .inst_data(d2_data), .inst_pc(d2_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Memory model: in-order queue of accepted requests, each with the cycle
  // it may return and the redirect epoch it was issued in.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;
  mreq_t memq[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          buffered = 0;
  int          mem_delay = 1;
  bit          rand_delay = 1'b0;
  bit          rst_next = 1'b0;
  int          npops = 0;
  logic [31:0] exp_fetch = RESET0;
  logic [31:0] exp_inst = RESET0;
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_data;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, then
  // advance the reference model by what will happen at the next rising edge.
  task automatic step(input bit ready, input bit iready, input bit redir, input logic [31:0] rpc);
    bit    take;
    bit    exp_rv;
    mreq_t m;
    @(negedge clk);
    rst = rst_next;
    if (!rst) begin
      memq.delete();
      buffered  = 0;
      exp_fetch = RESET0;
      exp_inst  = RESET0;
    end
    mem_req_ready  = ready;
    inst_ready     = iready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    take = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (rst && memq.size() > 0) begin
      if (memq[0].due <= cyc) begin
        take          = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = memword(memq[0].addr);
      end
    end
    #1;
    s_rv = mem_req_valid; s_addr = mem_req_addr;
    s_iv = inst_valid;    s_pc   = inst_pc;     s_data = inst_data;

    exp_rv = rst && !redir && ((memq.size() + buffered) < DEPTH);
    chk("req_valid", 32'(s_rv), 32'(exp_rv));
    if (exp_rv && s_rv) chk("req_addr", s_addr, exp_fetch);
    chk("inst_valid", 32'(s_iv), 32'(rst && (buffered > 0)));
    if (!rst) begin
      chk("rst_inst_data", s_data, 32'h0);
      chk("rst_inst_pc", s_pc, 32'h0);
    end

    if (rst && s_iv && iready) begin
      chk("pop_pc", s_pc, exp_inst);
      chk("pop_data", s_data, memword(exp_inst));
      exp_inst = exp_inst + 32'd4;
      buffered--;
      npops++;
    end
    if (take) begin
      m = memq.pop_front();
      if (m.epoch == epoch && !redir) buffered++;
    end
    if (rst && s_rv && ready) begin
      m.addr  = s_addr;
      m.due   = cyc + (rand_delay ? int'($urandom_range(1, 4)) : mem_delay);
      m.epoch = epoch;
      memq.push_back(m);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (rst && redir) begin
      epoch++;
      buffered  = 0;
      exp_fetch = {rpc[31:2], 2'b00};
      exp_inst  = {rpc[31:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_next = 1'b0;
    repeat (n) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_d2_valid", 32'(d2_rv), 32'h0);
    chk("rst_d2_ivalid", 32'(d2_iv), 32'h0);
    chk("rst_d2_data", d2_data, 32'h0);
    chk("rst_d2_pc", d2_pc, 32'h0);
    rst_next = 1'b1;
  endtask

  typedef struct {
    bit          rst_before;
    int          delay;
    bit          ready;
    bit          iready;
    bit          redir;
    logic [31:0] rpc;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int issued;
    // Steady stream from reset
    vecs[0]  = '{1, 1, 1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    vecs[1]  = '{0, 1, 1, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0};
    vecs[2]  = '{0, 1, 1, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0};
    vecs[3]  = '{0, 1, 1, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4};
    vecs[4]  = '{0, 1, 1, 1, 0, 32'h0,   1, 32'h10,  1, 32'h8};
    // Redirect with two requests in flight, stale responses dropped
    vecs[5]  = '{1, 3, 1, 1, 1, 32'h10,  0, 32'h0,   0, 32'h0};
    vecs[6]  = '{0, 3, 1, 1, 0, 32'h0,   1, 32'h10,  0, 32'h0};
    vecs[7]  = '{0, 3, 1, 1, 0, 32'h0,   1, 32'h14,  0, 32'h0};
    vecs[8]  = '{0, 3, 1, 1, 1, 32'h103, 0, 32'h0,   0, 32'h0};
    vecs[9]  = '{0, 3, 1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0};
    vecs[10] = '{0, 3, 1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0};
    vecs[11] = '{0, 3, 1, 1, 0, 32'h0,   1, 32'h108, 0, 32'h0};
    vecs[12] = '{0, 3, 1, 1, 0, 32'h0,   1, 32'h10C, 0, 32'h0};
    vecs[13] = '{0, 3, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h100};
    vecs[14] = '{0, 3, 1, 1, 0, 32'h0,   1, 32'h110, 1, 32'h104};
    // Redirect coincident with a response and a pop
    vecs[15] = '{1, 1, 1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    vecs[16] = '{0, 1, 1, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0};
    vecs[17] = '{0, 1, 1, 1, 1, 32'h200, 0, 32'h0,   1, 32'h0};
    vecs[18] = '{0, 1, 1, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0};
    vecs[19] = '{0, 1, 1, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0};

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].rst_before) do_reset(3);
      rand_delay = 1'b0;
      mem_delay  = vecs[i].delay;
      step(vecs[i].ready, vecs[i].iready, vecs[i].redir, vecs[i].rpc);
      chk($sformatf("tbl%0d_req_valid", i), 32'(s_rv), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("tbl%0d_req_addr", i), s_addr, vecs[i].e_addr);
      chk($sformatf("tbl%0d_inst_valid", i), 32'(s_iv), 32'(vecs[i].e_iv));
      if (vecs[i].e_iv) chk($sformatf("tbl%0d_inst_pc", i), s_pc, vecs[i].e_pc);
    end
    // Inst valid low the cycle after the redirect+pop row, then first new word
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_pop_next_pc", s_pc, 32'h200);

    // Buffer fill with the datapath stalled
    do_reset(2);
    mem_delay = 1;
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (s_rv) issued++;
    end
    chk("fill_req_count", 32'(issued), 32'd4);
    chk("fill_head_valid", 32'(s_iv), 32'h1);
    chk("fill_head_pc", s_pc, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("fill_pop_req_valid", 32'(s_rv), 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("fill_resume_valid", 32'(s_rv), 32'h1);
    chk("fill_resume_addr", s_addr, 32'h10);

    // Address wrap from a high reset PC
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk($sformatf("wrap%0d_valid", i), 32'(d2_rv), 32'h1);
      chk($sformatf("wrap%0d_addr", i), d2_addr, 32'hFFFF_FFF8 + 32'(4 * i));
    end

    // Randomized traffic, redirects and occasional mid-run resets
    rand_delay = 1'b1;
    npops = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rpc;
      if ($urandom_range(0, 799) == 0) do_reset(2);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, rpc);
    end
    chk("random_progress", 32'(npops > 300), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
